dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter.sv | 152 +++++++++++++++
 tb/tb_dmem_arbiter.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port single-memory access arbiter (IDLE/ACC/DONE).
// Define DMEM_ARB_ROUND_ROBIN_EN for round-robin on simultaneous requests; default is fixed p0 priority.
module dmem_arbiter #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_ack,
  output logic [DATA_W-1:0] p0_rdata,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_ack,
  output logic [DATA_W-1:0] p1_rdata,
  output logic [ADDR_W-1:0] mem_access_addr,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_write_en,
  output logic              mem_read,
  input  logic [DATA_W-1:0] mem_read_data,
  output logic              busy,
  output logic [1:0]        grant
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              sel_p1_q, sel_p1_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              p0_ack_q, p0_ack_d;
  logic              p1_ack_q, p1_ack_d;
  logic [DATA_W-1:0] p0_rdata_q, p0_rdata_d;
  logic [DATA_W-1:0] p1_rdata_q, p1_rdata_d;
  logic              win_p1;

`ifdef DMEM_ARB_ROUND_ROBIN_EN
  // last_grant_q = 1 means p1 was the most recent winner
  logic last_grant_q, last_grant_d;

  always_comb begin
    win_p1 = p1_req & (~p0_req | ~last_grant_q);
  end
`else
  always_comb begin
    win_p1 = p1_req & ~p0_req;
  end
`endif

  always_comb begin
    state_d    = state_q;
    sel_p1_d   = sel_p1_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    p0_ack_d   = 1'b0;
    p1_ack_d   = 1'b0;
    p0_rdata_d = p0_rdata_q;
    p1_rdata_d = p1_rdata_q;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
    last_grant_d = last_grant_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (p0_req || p1_req) begin
          state_d  = ST_ACC;
          sel_p1_d = win_p1;
          we_d     = win_p1 ? p1_we    : p0_we;
          addr_d   = win_p1 ? p1_addr  : p0_addr;
          wdata_d  = win_p1 ? p1_wdata : p0_wdata;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
          last_grant_d = win_p1;
`endif
        end
      end
      ST_ACC: begin
        state_d = ST_DONE;
        if (sel_p1_q) begin
          p1_ack_d = 1'b1;
          if (!we_q) p1_rdata_d = mem_read_data;
        end else begin
          p0_ack_d = 1'b1;
          if (!we_q) p0_rdata_d = mem_read_data;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      sel_p1_q   <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      p0_ack_q   <= 1'b0;
      p1_ack_q   <= 1'b0;
      p0_rdata_q <= '0;
      p1_rdata_q <= '0;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
      last_grant_q <= 1'b1;
`endif
    end else begin
      state_q    <= state_d;
      sel_p1_q   <= sel_p1_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      p0_ack_q   <= p0_ack_d;
      p1_ack_q   <= p1_ack_d;
      p0_rdata_q <= p0_rdata_d;
      p1_rdata_q <= p1_rdata_d;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
      last_grant_q <= last_grant_d;
`endif
    end
  end

  // Memory strobes decode straight from the state flop so reset kills them at once
  always_comb begin
    mem_access_addr = '0;
    mem_write_data  = '0;
    mem_write_en    = 1'b0;
    mem_read        = 1'b0;
    if (state_q == ST_ACC) begin
      mem_access_addr = addr_q;
      mem_write_data  = wdata_q;
      mem_write_en    = we_q;
      mem_read        = ~we_q;
    end
  end

  assign busy     = (state_q == ST_ACC) || (state_q == ST_DONE);
  assign grant    = busy ? (sel_p1_q ? 2'b10 : 2'b01) : 2'b00;
  assign p0_ack   = p0_ack_q;
  assign p1_ack   = p1_ack_q;
  assign p0_rdata = p0_rdata_q;
  assign p1_rdata = p1_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed plus randomized transaction-level checks of dmem_arbiter.
module tb_dmem_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic        p0_req, p0_we, p1_req, p1_we;
  logic [15:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
  logic        p0_ack, p1_ack;
  logic [15:0] p0_rdata, p1_rdata;
  logic [15:0] mem_access_addr, mem_write_data, mem_read_data;
  logic        mem_write_en, mem_read, busy;
  logic [1:0]  grant;

  int checks = 0;
  int errors = 0;

  dmem_arbiter #(.DATA_W(16), .ADDR_W(16)) dut (
    .clk(clk), .reset(reset),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_ack(p0_ack), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_ack(p1_ack), .p1_rdata(p1_rdata),
    .mem_access_addr(mem_access_addr), .mem_write_data(mem_write_data),
    .mem_write_en(mem_write_en), .mem_read(mem_read), .mem_read_data(mem_read_data),
    .busy(busy), .grant(grant)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] init_val(input logic [15:0] a);
    return (a * 16'h9E37) ^ 16'h5A5A;
  endfunction

  // Memory attached to the arbiter: unwritten words read back init_val
  logic [15:0] env_mem [0:65535];
  logic        env_wr  [0:65535];

  function automatic logic [15:0] env_read(input logic [15:0] a);
    return (env_wr[a] === 1'b1) ? env_mem[a] : init_val(a);
  endfunction

  assign mem_read_data = env_read(mem_access_addr);

  always @(posedge clk) begin
    if (mem_write_en) begin
      env_mem[mem_access_addr] <= mem_write_data;
      env_wr[mem_access_addr]  <= 1'b1;
    end
  end

  // Reference model: transaction-level memory image, expected rdata, arbitration history
  logic [15:0] ref_mem [int];
  logic [15:0] exp_rd [2];
  bit          last_p1;
  bit          pend [2];
  bit          pwe [2];
  logic [15:0] paddr [2];
  logic [15:0] pwdata [2];

  function automatic logic [15:0] ref_read(input logic [15:0] a);
    return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : init_val(a);
  endfunction

  function automatic int pick(input bit r0, input bit r1);
    if (r0 && r1) begin
`ifdef DMEM_ARB_ROUND_ROBIN_EN
      return last_p1 ? 0 : 1;
`else
      return 0;
`endif
    end
    return r1 ? 1 : 0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply();
    p0_req = pend[0]; p0_we = pwe[0]; p0_addr = paddr[0]; p0_wdata = pwdata[0];
    p1_req = pend[1]; p1_we = pwe[1]; p1_addr = paddr[1]; p1_wdata = pwdata[1];
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_ack0"}, 32'(p0_ack), 32'd0);
    chk({tag, "_ack1"}, 32'(p1_ack), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_grant"}, 32'(grant), 32'd0);
    chk({tag, "_mem"}, {mem_access_addr, mem_write_data} | 32'({mem_write_en, mem_read}), 32'd0);
  endtask

  task automatic model_reset();
    last_p1 = 1'b1;
    exp_rd[0] = '0;
    exp_rd[1] = '0;
  endtask

  // One full transaction starting in IDLE with current requests already driven
  task automatic run_txn(input string tag);
    int w;
    w = pick(pend[0], pend[1]);
    last_p1 = (w == 1);
    tick();
    chk({tag, "_acc_grant"}, 32'(grant), (w == 0) ? 32'd1 : 32'd2);
    chk({tag, "_acc_busy"}, 32'(busy), 32'd1);
    chk({tag, "_acc_addr"}, 32'(mem_access_addr), 32'(paddr[w]));
    chk({tag, "_acc_wdata"}, 32'(mem_write_data), 32'(pwdata[w]));
    chk({tag, "_acc_we"}, 32'(mem_write_en), 32'(pwe[w]));
    chk({tag, "_acc_rd"}, 32'(mem_read), 32'(!pwe[w]));
    chk({tag, "_acc_acks"}, 32'({p1_ack, p0_ack}), 32'd0);
    if (w == 0) begin
      p0_addr = paddr[0] ^ 16'h0004; p0_wdata = ~pwdata[0]; p0_we = ~pwe[0];
    end else begin
      p1_addr = paddr[1] ^ 16'h0004; p1_wdata = ~pwdata[1]; p1_we = ~pwe[1];
    end
    if (pwe[w]) ref_mem[int'(paddr[w])] = pwdata[w];
    else exp_rd[w] = ref_read(paddr[w]);
    tick();
    chk({tag, "_done_acks"}, 32'({p1_ack, p0_ack}), (w == 0) ? 32'd1 : 32'd2);
    chk({tag, "_done_busy"}, 32'(busy), 32'd1);
    chk({tag, "_done_grant"}, 32'(grant), (w == 0) ? 32'd1 : 32'd2);
    chk({tag, "_done_mem"}, {mem_access_addr, mem_write_data} | 32'({mem_write_en, mem_read}), 32'd0);
    chk({tag, "_rdata0"}, 32'(p0_rdata), 32'(exp_rd[0]));
    chk({tag, "_rdata1"}, 32'(p1_rdata), 32'(exp_rd[1]));
    pend[w] = 1'b0;
    apply();
    tick();
    chk_quiet({tag, "_idle"});
    if (pwe[w]) chk({tag, "_memword"}, 32'(env_read(paddr[w])), 32'(pwdata[w]));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      pend[i] = 0; pwe[i] = 0; paddr[i] = '0; pwdata[i] = '0;
    end
    apply();
    model_reset();
    tick();
    tick();
    chk_quiet("reset");
    chk("reset_rdata", {p1_rdata, p0_rdata}, 32'd0);
    reset = 1'b0;
    tick();
    chk_quiet("post_reset");

    // p0 write then read back address 3
    pend[0] = 1; pwe[0] = 1; paddr[0] = 16'd3; pwdata[0] = 16'hA5A5; apply();
    run_txn("p0_wr3");
    pend[0] = 1; pwe[0] = 0; paddr[0] = 16'd3; apply();
    run_txn("p0_rd3");
    chk("p0_rd3_val", 32'(p0_rdata), 32'h0000A5A5);

    // simultaneous reads of addresses 1 and 2
    pend[0] = 1; pwe[0] = 0; paddr[0] = 16'd1;
    pend[1] = 1; pwe[1] = 0; paddr[1] = 16'd2; apply();
    run_txn("both_a");
    apply();
    run_txn("both_b");

    // both held high: p0 re-requests immediately every time
    pend[1] = 1; pwe[1] = 0; paddr[1] = 16'd2;
    for (int k = 0; k < 3; k++) begin
      pend[0] = 1; pwe[0] = 0; paddr[0] = 16'd1; apply();
      run_txn("hold");
    end
    while (pend[0] || pend[1]) begin
      apply();
      run_txn("drain");
    end

    // address changed from 2 to 6 during ACC must not matter
    pend[0] = 1; pwe[0] = 0; paddr[0] = 16'd2; apply();
    run_txn("addr_hold");
    chk("addr_hold_val", 32'(p0_rdata), 32'(init_val(16'd2)));

    // reset in the middle of a p1 write
    pend[1] = 1; pwe[1] = 1; paddr[1] = 16'd5; pwdata[1] = 16'h1234; apply();
    tick();
    chk("rst_acc_we", 32'(mem_write_en), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk_quiet("rst_async");
    chk("rst_async_rdata", {p1_rdata, p0_rdata}, 32'd0);
    pend[1] = 0; apply();
    model_reset();
    tick();
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk_quiet("rst_after");
    end
    chk("rst_mem5", 32'(env_read(16'd5)), 32'(ref_read(16'd5)));

    // randomized traffic
    for (int it = 0; it < 150; it++) begin
      for (int p = 0; p < 2; p++) begin
        if (!pend[p] && ($urandom_range(0, 1) == 1)) begin
          pend[p]   = 1;
          pwe[p]    = $urandom_range(0, 1) == 1;
          paddr[p]  = ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'($urandom_range(0, 15));
          pwdata[p] = 16'($urandom);
        end
      end
      apply();
      if (pend[0] || pend[1]) run_txn("rand");
      else begin
        tick();
        chk_quiet("rand_idle");
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
